// File: rtl/spc_image_writer.sv
// spc_image_writer: decodes the SPC file byte stream from the SD loader into
// CPU boot registers, APU RAM writes (ready handshake) and DSP register writes.
// Holds the APU in reset until the whole image is committed.
// Optional: define SPC_EXTRA_RAM_EN to write file offsets 0x101C0-0x101FF to
// RAM 0xFFC0-0xFFFF after the main image.
module spc_image_writer #(
   parameter int unsigned FIFO_AW = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        load_done,
   input  logic        load_fail,
   input  logic [7:0]  in_data,
   input  logic [16:0] in_addr,
   input  logic        in_valid,
   output logic        ram_we,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_din,
   input  logic        ram_ready,
   output logic        dsp_we,
   output logic [6:0]  dsp_addr,
   output logic [7:0]  dsp_din,
   output logic [15:0] cpu_pc,
   output logic [7:0]  cpu_a,
   output logic [7:0]  cpu_x,
   output logic [7:0]  cpu_y,
   output logic [7:0]  cpu_psw,
   output logic [7:0]  cpu_sp,
   output logic        apu_reset,
   output logic        finished,
   output logic        error,
   output logic        overflow
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMMIT, S_DONE, S_FAIL} state_t;

   state_t              r_state, w_next;
   logic                r_first;
   logic [24:0]         r_mem [DEPTH];
   logic [FIFO_AW-1:0]  r_wp, r_rp;
   logic [FIFO_AW:0]    r_cnt;
   logic                r_ram_we, r_dsp_we, r_hdr_bad;
   logic                r_finished, r_error, r_apu_reset, r_overflow;
   logic [15:0]         r_ram_addr, r_pc;
   logic [7:0]          r_ram_din, r_dsp_din, r_a, r_x, r_y, r_psw, r_sp;
   logic [6:0]          r_dsp_addr;

   logic                w_empty, w_full, w_active, w_kill;
   logic                w_head_ram, w_head_dsp, w_pop, w_push_req, w_push, w_drop;
   logic [16:0]         w_head_addr;
   logic [7:0]          w_head_data;
   logic [15:0]         w_ram_a;

   assign w_head_addr = r_mem[r_rp][24:8];
   assign w_head_data = r_mem[r_rp][7:0];
   assign w_empty     = (r_cnt == '0);
   assign w_full      = (r_cnt == (FIFO_AW+1)'(DEPTH));

   // State register; r_first masks the loader's stale done level after start
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_first <= 1'b0;
      end else begin
         r_state <= w_next;
         r_first <= start;
      end
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      if (start) begin
         w_next = S_LOAD;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (load_fail)                 w_next = S_FAIL;
               else if (load_done && !r_first) w_next = S_COMMIT;
            end
            S_COMMIT: begin
               if (w_empty && !r_ram_we)
                  w_next = (r_hdr_bad || r_overflow) ? S_FAIL : S_DONE;
            end
            default: ;
         endcase
      end
   end

   // FIFO head decode and push/pop control
   always_comb begin
      w_active   = (r_state == S_LOAD) || (r_state == S_COMMIT);
      w_kill     = start || (w_next == S_FAIL);
      w_head_dsp = (w_head_addr[16:7] == 10'h202);
      w_head_ram = (w_head_addr >= 17'h00100) && (w_head_addr <= 17'h100FF);
      w_ram_a    = w_head_addr[15:0] - 16'h0100;
`ifdef SPC_EXTRA_RAM_EN
      if (w_head_addr[16:6] == 11'h407) begin
         w_head_ram = 1'b1;
         w_ram_a    = {10'h3FF, w_head_addr[5:0]};
      end
`endif
      // a RAM entry may leave the FIFO once the output slot is free or being accepted
      w_pop      = w_active && !w_kill && !w_empty &&
                   (!w_head_ram || !r_ram_we || ram_ready);
      w_push_req = in_valid && (r_state == S_LOAD) && !w_kill;
      w_push     = w_push_req && (!w_full || w_pop);
      w_drop     = w_push_req && w_full && !w_pop;
   end

   // Skid FIFO pointers and occupancy; flushed on start and on failure
   always_ff @(posedge clk) begin
      if (!resetn || w_kill) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + FIFO_AW'(1);
         if (w_pop)  r_rp <= r_rp + FIFO_AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (FIFO_AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (FIFO_AW+1)'(1);
            default: ;
         endcase
      end
   end

   // Skid FIFO storage
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= {in_addr, in_data};
   end

   // RAM write port: request held until accepted, cancelled on start/failure
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_ram_we   <= 1'b0;
         r_ram_addr <= '0;
         r_ram_din  <= '0;
      end else if (w_kill) begin
         r_ram_we <= 1'b0;
      end else if (w_pop && w_head_ram) begin
         r_ram_we   <= 1'b1;
         r_ram_addr <= w_ram_a;
         r_ram_din  <= w_head_data;
      end else if (ram_ready) begin
         r_ram_we <= 1'b0;
      end
   end

   // DSP register write: one-cycle strobe after the pop
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_dsp_we   <= 1'b0;
         r_dsp_addr <= '0;
         r_dsp_din  <= '0;
      end else begin
         r_dsp_we <= w_pop && w_head_dsp;
         if (w_pop && w_head_dsp) begin
            r_dsp_addr <= w_head_addr[6:0];
            r_dsp_din  <= w_head_data;
         end
      end
   end

   // Header capture and signature check
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_hdr_bad <= 1'b0;
         r_pc      <= '0;
         r_a       <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_psw     <= '0;
         r_sp      <= '0;
      end else if (start) begin
         r_hdr_bad <= 1'b0;
      end else if (w_pop) begin
         case (w_head_addr)
            17'h00021, 17'h00022: if (w_head_data != 8'h1A) r_hdr_bad <= 1'b1;
            17'h00025: r_pc[7:0]  <= w_head_data;
            17'h00026: r_pc[15:8] <= w_head_data;
            17'h00027: r_a        <= w_head_data;
            17'h00028: r_x        <= w_head_data;
            17'h00029: r_y        <= w_head_data;
            17'h0002A: r_psw      <= w_head_data;
            17'h0002B: r_sp       <= w_head_data;
            default: ;
         endcase
      end
   end

   // Status outputs, registered from the next state so they change on entry
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_finished  <= 1'b0;
         r_error     <= 1'b0;
         r_apu_reset <= 1'b1;
         r_overflow  <= 1'b0;
      end else begin
         r_finished  <= (w_next == S_DONE);
         r_error     <= (w_next == S_FAIL);
         r_apu_reset <= (w_next != S_DONE);
         if (start)       r_overflow <= 1'b0;
         else if (w_drop) r_overflow <= 1'b1;
      end
   end

   assign ram_we    = r_ram_we;
   assign ram_addr  = r_ram_addr;
   assign ram_din   = r_ram_din;
   assign dsp_we    = r_dsp_we;
   assign dsp_addr  = r_dsp_addr;
   assign dsp_din   = r_dsp_din;
   assign cpu_pc    = r_pc;
   assign cpu_a     = r_a;
   assign cpu_x     = r_x;
   assign cpu_y     = r_y;
   assign cpu_psw   = r_psw;
   assign cpu_sp    = r_sp;
   assign apu_reset = r_apu_reset;
   assign finished  = r_finished;
   assign error     = r_error;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_spc_image_writer.sv
// Directed bench for spc_image_writer: full image, throttled RAM, overflow,
// bad header, loader failure and the extra RAM region.
module tb_spc_image_writer;

   logic        clk = 1'b0, resetn = 1'b0, start = 1'b0;
   logic        load_done = 1'b0, load_fail = 1'b0, in_valid = 1'b0, ram_ready = 1'b1;
   logic [7:0]  in_data = '0;
   logic [16:0] in_addr = '0;
   logic        ram_we, dsp_we, apu_reset, finished, error, overflow;
   logic [15:0] ram_addr, cpu_pc;
   logic [7:0]  ram_din, dsp_din, cpu_a, cpu_x, cpu_y, cpu_psw, cpu_sp;
   logic [6:0]  dsp_addr;

   spc_image_writer #(.FIFO_AW(2)) dut (
      .clk(clk), .resetn(resetn), .start(start), .load_done(load_done),
      .load_fail(load_fail), .in_data(in_data), .in_addr(in_addr),
      .in_valid(in_valid), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_ready(ram_ready), .dsp_we(dsp_we),
      .dsp_addr(dsp_addr), .dsp_din(dsp_din), .cpu_pc(cpu_pc),
      .cpu_a(cpu_a), .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_psw(cpu_psw),
      .cpu_sp(cpu_sp), .apu_reset(apu_reset), .finished(finished),
      .error(error), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int hs_cnt = 0, dsp_cnt = 0, sb_bad = 0, viol = 0;
   int b_hs, b_dsp, b_sb, b_viol;
   int rdy_mode = 0, rdy_ph = 0;
   bit sb_en = 1'b0;
   logic [23:0] exp_ram[$];
   logic [14:0] exp_dsp[$];
   logic [23:0] e_ram, prev_val;
   logic [14:0] e_dsp;
   logic        prev_stall = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] img(input logic [16:0] o);
      case (o)
         17'h00021, 17'h00022: return 8'h1A;
         17'h00025: return 8'h00;
         17'h00026: return 8'h04;
         17'h00027: return 8'h11;
         17'h00028: return 8'h22;
         17'h00029: return 8'h33;
         17'h0002A: return 8'h02;
         17'h0002B: return 8'hEF;
         default:   return o[7:0] ^ o[15:8] ^ {o[16], 7'b0};
      endcase
   endfunction

   // drive one byte, queueing the RAM/DSP writes the offset should produce
   task automatic send(input logic [16:0] o, input logic [7:0] d, input int unsigned gap);
      logic [16:0] a;
      if (sb_en) begin
         if (o >= 17'h00100 && o <= 17'h100FF) begin
            a = o - 17'h00100;
            exp_ram.push_back({a[15:0], d});
         end
`ifdef SPC_EXTRA_RAM_EN
         if (o >= 17'h101C0 && o <= 17'h101FF) exp_ram.push_back({10'h3FF, o[5:0], d});
`endif
         if (o >= 17'h10100 && o <= 17'h1017F) exp_dsp.push_back({o[6:0], d});
      end
      in_addr = o; in_data = d; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      for (int i = 0; i < 300 && !(finished || error); i++) begin
         @(posedge clk); #1;
      end
      chk({tag, " end reached"}, 32'(finished || error), 32'd1);
   endtask

   task automatic snap();
      b_hs = hs_cnt; b_dsp = dsp_cnt; b_sb = sb_bad; b_viol = viol;
   endtask

   // ram_ready pattern generator
   initial begin
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: ram_ready = 1'b1;
            1: begin ram_ready = (rdy_ph == 0); rdy_ph = (rdy_ph + 1) % 3; end
            default: ram_ready = 1'b0;
         endcase
      end
   end

   // Output monitor: handshakes against the queued writes, stall stability
   always @(negedge clk) begin
      if (ram_we && ram_ready) begin
         hs_cnt++;
         if (sb_en) begin
            if (exp_ram.size() == 0) sb_bad++;
            else begin
               e_ram = exp_ram.pop_front();
               if (e_ram !== {ram_addr, ram_din}) sb_bad++;
            end
         end
      end
      if (prev_stall && ram_we && ({ram_addr, ram_din} !== prev_val)) sb_bad++;
      prev_stall = ram_we && !ram_ready;
      prev_val   = {ram_addr, ram_din};
      if (dsp_we) begin
         dsp_cnt++;
         if (sb_en) begin
            if (exp_dsp.size() == 0) sb_bad++;
            else begin
               e_dsp = exp_dsp.pop_front();
               if (e_dsp !== {dsp_addr, dsp_din}) sb_bad++;
            end
         end
      end
      if (error && (ram_we || dsp_we)) viol++;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst apu_reset", 32'(apu_reset), 32'd1);
      chk("rst finished", 32'(finished), 32'd0);
      chk("rst error", 32'(error), 32'd0);
      chk("rst overflow", 32'(overflow), 32'd0);
      chk("rst ram_we", 32'(ram_we), 32'd0);
      chk("rst dsp_we", 32'(dsp_we), 32'd0);
      chk("rst cpu_pc", 32'(cpu_pc), 32'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // full image at 1 byte/cycle
      sb_en = 1'b1; exp_ram.delete(); exp_dsp.delete(); snap();
      do_start();
      for (int o = 0; o < 'h10200; o++) send(17'(o), img(17'(o)), 0);
      load_done = 1'b1;
      wait_end("full");
      chk("full finished", 32'(finished), 32'd1);
      chk("full error", 32'(error), 32'd0);
      chk("full apu_reset", 32'(apu_reset), 32'd0);
      chk("full cpu_pc", 32'(cpu_pc), 32'h0400);
      chk("full cpu_a", 32'(cpu_a), 32'h11);
      chk("full cpu_x", 32'(cpu_x), 32'h22);
      chk("full cpu_y", 32'(cpu_y), 32'h33);
      chk("full cpu_psw", 32'(cpu_psw), 32'h02);
      chk("full cpu_sp", 32'(cpu_sp), 32'hEF);
`ifdef SPC_EXTRA_RAM_EN
      chk("full ram handshakes", 32'(hs_cnt - b_hs), 32'd65600);
`else
      chk("full ram handshakes", 32'(hs_cnt - b_hs), 32'd65536);
`endif
      chk("full dsp pulses", 32'(dsp_cnt - b_dsp), 32'd128);
      chk("full write order/data", 32'(sb_bad - b_sb), 32'd0);
      chk("full ram queue drained", 32'(exp_ram.size()), 32'd0);

      // stale load_done held through the start cycle and the one after
      rdy_mode = 1; exp_ram.delete(); exp_dsp.delete(); snap();
      do_start();
      chk("stale finished cleared", 32'(finished), 32'd0);
      chk("stale apu_reset set", 32'(apu_reset), 32'd1);
      @(posedge clk); #1;
      load_done = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("stale done ignored", 32'(finished), 32'd0);

      // ram_ready 1-of-3, a byte every 4 cycles
      send(17'h00021, 8'h1A, 3);
      send(17'h00022, 8'h1A, 3);
      for (int i = 0; i < 12; i++) send(17'h00200 + 17'(i), 8'hA0 + 8'(i), 3);
      load_done = 1'b1;
      wait_end("thr");
      chk("thr overflow", 32'(overflow), 32'd0);
      chk("thr finished", 32'(finished), 32'd1);
      chk("thr handshakes", 32'(hs_cnt - b_hs), 32'd12);
      chk("thr order/stability", 32'(sb_bad - b_sb), 32'd0);
      rdy_mode = 0;

      // RAM stalled while 6 RAM bytes arrive
      sb_en = 1'b0; rdy_mode = 2; snap();
      load_done = 1'b0;
      do_start();
      for (int i = 0; i < 6; i++) send(17'h00300 + 17'(i), 8'h60 + 8'(i), 0);
      chk("ovf overflow", 32'(overflow), 32'd1);
      chk("ovf ram_we held", 32'(ram_we), 32'd1);
      chk("ovf ram_addr held", 32'(ram_addr), 32'h0200);
      chk("ovf ram_din held", 32'(ram_din), 32'h60);
      repeat (4) begin @(posedge clk); #1; end
      rdy_mode = 0;
      load_done = 1'b1;
      wait_end("ovf");
      chk("ovf error", 32'(error), 32'd1);
      chk("ovf finished", 32'(finished), 32'd0);
      chk("ovf apu_reset", 32'(apu_reset), 32'd1);
      chk("ovf handshakes", 32'(hs_cnt - b_hs), 32'd5);

      // bad signature byte at 0x21
      sb_en = 1'b1; exp_ram.delete(); exp_dsp.delete(); snap();
      load_done = 1'b0;
      do_start();
      chk("hdr error cleared", 32'(error), 32'd0);
      chk("hdr overflow cleared", 32'(overflow), 32'd0);
      send(17'h00021, 8'h00, 0);
      send(17'h00022, 8'h1A, 0);
      send(17'h00025, 8'h78, 0);
      send(17'h00026, 8'h56, 0);
      for (int i = 0; i < 4; i++) send(17'h01000 + 17'(i), 8'hC0 + 8'(i), 0);
      load_done = 1'b1;
      wait_end("hdr");
      chk("hdr error", 32'(error), 32'd1);
      chk("hdr finished", 32'(finished), 32'd0);
      chk("hdr apu_reset", 32'(apu_reset), 32'd1);
      chk("hdr cpu_pc", 32'(cpu_pc), 32'h5678);
      chk("hdr handshakes", 32'(hs_cnt - b_hs), 32'd4);
      chk("hdr write data", 32'(sb_bad - b_sb), 32'd0);

      // loader failure mid-stream, then a clean reload
      sb_en = 1'b0; snap();
      load_done = 1'b0;
      do_start();
      for (int i = 0; i < 3; i++) send(17'h00400 + 17'(i), 8'h10 + 8'(i), 0);
      send(17'h10110, 8'h77, 0);
      load_fail = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(17'h00500 + 17'(i), 8'h20 + 8'(i), 0);
         send(17'h10120 + 17'(i), 8'h30 + 8'(i), 0);
      end
      repeat (5) begin @(posedge clk); #1; end
      chk("fail error", 32'(error), 32'd1);
      chk("fail finished", 32'(finished), 32'd0);
      chk("fail apu_reset", 32'(apu_reset), 32'd1);
      chk("fail ram_we", 32'(ram_we), 32'd0);
      chk("fail strobes after error", 32'(viol - b_viol), 32'd0);
      load_fail = 1'b0;
      sb_en = 1'b1; exp_ram.delete(); exp_dsp.delete(); snap();
      do_start();
      chk("reload error cleared", 32'(error), 32'd0);
      send(17'h00021, 8'h1A, 0);
      send(17'h00022, 8'h1A, 0);
      send(17'h00025, 8'h34, 0);
      send(17'h00026, 8'h12, 0);
      send(17'h00027, 8'h5A, 0);
      send(17'h00100, 8'h99, 0);
      send(17'h00101, 8'h98, 0);
      send(17'h1017F, 8'h42, 0);
      load_done = 1'b1;
      wait_end("reload");
      chk("reload finished", 32'(finished), 32'd1);
      chk("reload error", 32'(error), 32'd0);
      chk("reload apu_reset", 32'(apu_reset), 32'd0);
      chk("reload cpu_pc", 32'(cpu_pc), 32'h1234);
      chk("reload cpu_a", 32'(cpu_a), 32'h5A);
      chk("reload handshakes", 32'(hs_cnt - b_hs), 32'd2);
      chk("reload dsp pulses", 32'(dsp_cnt - b_dsp), 32'd1);
      chk("reload write data", 32'(sb_bad - b_sb), 32'd0);

      // extra RAM region after the main image byte for 0xFFC0
      exp_ram.delete(); exp_dsp.delete(); snap();
      load_done = 1'b0;
      do_start();
      send(17'h100C0, 8'h55, 0);
      send(17'h101C0, 8'hAA, 0);
      send(17'h10105, 8'h3C, 0);
      load_done = 1'b1;
      wait_end("extra");
      chk("extra finished", 32'(finished), 32'd1);
      chk("extra last ram_addr", 32'(ram_addr), 32'hFFC0);
`ifdef SPC_EXTRA_RAM_EN
      chk("extra handshakes", 32'(hs_cnt - b_hs), 32'd2);
      chk("extra last ram_din", 32'(ram_din), 32'hAA);
`else
      chk("extra handshakes", 32'(hs_cnt - b_hs), 32'd1);
      chk("extra last ram_din", 32'(ram_din), 32'h55);
`endif
      chk("extra dsp pulses", 32'(dsp_cnt - b_dsp), 32'd1);
      chk("extra write data", 32'(sb_bad - b_sb), 32'd0);
      chk("extra ram queue drained", 32'(exp_ram.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spc_image_writer.md
Name: spc_image_writer

Overview:
- Sits directly downstream of the SD SPC loader and consumes its byte stream (data, 17-bit file offset, valid pulse).
- Decodes each 0x10200-byte SPC image by offset:
  - header fields go to CPU boot registers;
  - the 64 KB RAM image goes to the APU RAM write port, which has a ready handshake;
  - the 128 DSP register bytes go to the DSP register write port.
- Holds the APU in reset while loading and releases it, with registers valid, once the image is fully committed.

Parameters:
- FIFO_AW, 2: log2 of the input skid FIFO depth (depth 4). Absorbs RAM back-pressure.

Ports:
- clk, input, 1: clock.
- resetn, input, 1: synchronous, active-low reset.
- start, input, 1: pulse; same pulse sent to the loader; begins a new image.
- load_done, input, 1: loader done level.
- load_fail, input, 1: loader fail level.
- in_data, input, 8: file byte.
- in_addr, input, 17: file offset of in_data.
- in_valid, input, 1: one-cycle strobe; no back-pressure to the loader.
- ram_we, output, 1: RAM write request.
- ram_addr, output, 16: RAM address.
- ram_din, output, 8: RAM write data.
- ram_ready, input, 1: RAM accepts the request this cycle.
- dsp_we, output, 1: single-cycle DSP register write strobe.
- dsp_addr, output, 7: DSP register address.
- dsp_din, output, 8: DSP register data.
- cpu_pc, output, 16: captured boot PC.
- cpu_a, output, 8: captured A.
- cpu_x, output, 8: captured X.
- cpu_y, output, 8: captured Y.
- cpu_psw, output, 8: captured PSW.
- cpu_sp, output, 8: captured SP.
- apu_reset, output, 1: holds the APU in reset.
- finished, output, 1: image committed successfully (level).
- error, output, 1: load failed (level).
- overflow, output, 1: sticky; an input byte was dropped.

Behaviour:
- Reset values: all outputs 0 except apu_reset=1. State=IDLE. FIFO empty.
- States: IDLE, LOAD, COMMIT, DONE, FAIL.
- start from any state:
  - go to LOAD and flush the FIFO;
  - clear finished, error, overflow and the header check flags;
  - set apu_reset=1. cpu_* keep their old values until overwritten.
- LOAD, input side:
  - each in_valid pushes {in_addr, in_data} into the FIFO;
  - if the FIFO is full, the byte is dropped and overflow=1 (sticky);
  - a simultaneous push and pop when full is allowed (no drop).
- LOAD, FIFO head decode, by offset:
  - 0x21: must be 0x1A, else hdr_bad.
  - 0x22: must be 0x1A, else hdr_bad.
  - 0x25: cpu_pc[7:0].
  - 0x26: cpu_pc[15:8].
  - 0x27: cpu_a.
  - 0x28: cpu_x.
  - 0x29: cpu_y.
  - 0x2A: cpu_psw.
  - 0x2B: cpu_sp.
  - 0x00100-0x100FF: RAM write, ram_addr = offset-0x100 (low 16 bits).
  - 0x10100-0x1017F: DSP write, dsp_addr = offset[6:0].
  - 0x101C0-0x101FF: see the optional feature.
  - All other offsets: discarded.
- Non-RAM entries pop in 1 cycle. dsp_we pulses exactly 1 cycle, registered, in the cycle after the pop.
- RAM handshake:
  - ram_we/ram_addr/ram_din are registered and held stable until ram_ready=1 in a cycle with ram_we=1.
  - The next entry may present on the following cycle, so throughput is 1 byte/cycle when ram_ready stays high.
  - ram_ready is ignored when ram_we=0.
  - RAM writes are issued in FIFO order.
- Transitions out of LOAD:
  - load_fail=1 → FAIL.
  - load_done=1 → COMMIT. load_done is ignored in the start cycle and the cycle after it, because the loader's done level is stale there.
- COMMIT: continue draining until the FIFO is empty and no RAM write is outstanding. Then:
  - hdr_bad or overflow → FAIL;
  - otherwise → DONE.
- DONE: finished=1 and apu_reset=0, both in the cycle DONE is entered, registered. Stay until start.
- FAIL: error=1, apu_reset stays 1, RAM/DSP strobes forced 0, FIFO flushed. Stay until start.
- start during an outstanding RAM write: ram_we drops on the next cycle. The RAM port treats a dropped request as cancelled.
- The block only decodes offsets; no count check on image completeness.

Optional Feature:
- Macro: SPC_EXTRA_RAM_EN.
- Defined: offsets 0x101C0-0x101FF are written to RAM 0xFFC0-0xFFFF through the same handshake, after the main image since stream order is preserved, overwriting the IPL shadow area.
- Undefined: those offsets are discarded and RAM 0xFFC0-0xFFFF keeps the main-image bytes.

Test Plan:
- Full image at 1 byte/cycle with ram_ready=1, load_done afterwards:
  - 65536 ram_we handshakes with ram_addr 0x0000-0xFFFF matching the data;
  - 128 dsp_we pulses;
  - cpu_pc equals bytes 0x26:0x25 (e.g. 0x0400);
  - finished=1, apu_reset=0.
- ram_ready toggling 1-of-3 while bytes arrive every 4 cycles:
  - no overflow, all writes in order, address/data held stable during stalls.
- ram_ready=0 for 10 cycles while 6 consecutive RAM bytes arrive, FIFO_AW=2:
  - overflow=1, byte(s) dropped;
  - after load_done → error=1, apu_reset=1.
- Byte 0x21=0x00 with the rest valid → error=1 after the drain, finished=0.
- load_fail asserted mid-stream → FAIL: no further ram_we/dsp_we, error=1. A new start then clears error and reloads.
- Extra RAM bytes, with and without SPC_EXTRA_RAM_EN:
  - defined: ram_addr 0xFFC0 written with byte 0x101C0 after the main write to 0xFFC0;
  - undefined: no such write.
